systolic_feeder: RTL

Front-end driver for the systolic array datapath. It is the writer side of the array's weight/feature load interface: it accepts one weight tile and a stream of feature vectors from upstream over valid/ready handshakes. It drives `weight_input2`/`weight_en` row by row, issues the one-cycle `conv_ctrl` start with `weight_dim`, then streams features with the diagonal skew the array requires (lane r delayed r cycles, per-lane `in_en`). It sits between the buffer/DMA layer and `systolic_top`, and signals completion once the skew pipeline has drained.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/skew_lane.sv | 43 ++++
 rtl/systolic_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic array front end.
// Holds the feeder FSM state encoding and the tile-dimension width.
package systolic_pkg;

  localparam int DIM_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CTRL,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// skew_lane: fixed-depth delay line carrying a data word plus a valid bit.
// Ports: clk, nrst (async, active-high), d_in/v_in in, d_out/v_out after depth cycles.
module skew_lane #(
  parameter int width = 8,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [width-1:0] d_in,
  input  logic             v_in,
  output logic [width-1:0] d_out,
  output logic             v_out
);

  logic [depth-1:0][width-1:0] d_q, d_d;
  logic [depth-1:0]            v_q, v_d;

  // Invalid slots carry zero data so the array never sees stale values.
  always_comb begin
    d_d    = d_q;
    v_d    = v_q;
    d_d[0] = v_in ? d_in : '0;
    v_d[0] = v_in;
    for (int i = 1; i < depth; i++) begin
      d_d[i] = d_q[i-1];
      v_d[i] = v_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      d_q <= '0;
      v_q <= '0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  assign d_out = d_q[depth-1];
  assign v_out = v_q[depth-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads one weight tile, starts the array, then streams skewed features.
// Ports: start/k_dim request, w_* and f_* valid/ready inputs, weight/feature/ctrl outputs to array, busy/done.
import systolic_pkg::*;

module systolic_feeder #(
  parameter int width = 8,
  parameter int col   = 4,
  parameter int row   = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       start,
  input  logic [DIM_W-1:0]           k_dim,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [col-1:0][width-1:0]  w_data,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [row-1:0][width-1:0]  f_data,
  output logic [col-1:0][width-1:0]  weight_input2,
  output logic [col-1:0]             weight_en,
  output logic [row-1:0][width-1:0]  feature_input2,
  output logic [row-1:0]             in_en,
  output logic                       conv_ctrl,
  output logic [DIM_W-1:0]           weight_dim,
  output logic                       busy,
  output logic                       done
);

  localparam logic [DIM_W-1:0] ROW_LAST = DIM_W'(row - 1);

  feeder_state_t state_q, state_d;
  logic [DIM_W-1:0] wcnt_q, wcnt_d;
  logic [DIM_W-1:0] fcnt_q, fcnt_d;
  logic [DIM_W-1:0] dcnt_q, dcnt_d;
  logic [DIM_W-1:0] dim_q, dim_d;
  logic [col-1:0][width-1:0] wi_q, wi_d;
  logic [col-1:0] wen_q, wen_d;
  logic w_ready_q, w_ready_d;
  logic f_ready_q, f_ready_d;
  logic conv_q, conv_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic w_acc, f_acc;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    dim_d   = dim_q;
    conv_d  = 1'b0;
    done_d  = 1'b0;
    w_acc   = w_valid && w_ready_q;
    f_acc   = f_valid && f_ready_q;
    wi_d    = w_acc ? w_data : '0;
    wen_d   = w_acc ? '1 : '0;
    unique case (state_q)
      IDLE: begin
        // A start landing on the done cycle is dropped.
        if (start && k_dim != '0 && !done_q) begin
          dim_d   = k_dim;
          wcnt_d  = '0;
          fcnt_d  = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          if (wcnt_q == ROW_LAST) state_d = CTRL;
          else wcnt_d = wcnt_q + 1'b1;
        end
      end
      CTRL: begin
        conv_d  = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (f_acc) begin
          fcnt_d = fcnt_q + 1'b1;
          if (fcnt_d == dim_q) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        // The deepest lane empties row cycles after the last accept.
        if (dcnt_q == ROW_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    w_ready_d = (state_d == LOAD_W);
    // Holding off one STREAM cycle puts f_ready right after conv_ctrl.
    f_ready_d = (state_q == STREAM) && (state_d == STREAM) && (fcnt_d < dim_q);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      fcnt_q    <= '0;
      dcnt_q    <= '0;
      dim_q     <= '0;
      wi_q      <= '0;
      wen_q     <= '0;
      w_ready_q <= 1'b0;
      f_ready_q <= 1'b0;
      conv_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
      dim_q     <= dim_d;
      wi_q      <= wi_d;
      wen_q     <= wen_d;
      w_ready_q <= w_ready_d;
      f_ready_q <= f_ready_d;
      conv_q    <= conv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_lane
    skew_lane #(
      .width(width),
      .depth(r + 1)
    ) u_lane (
      .clk  (clk),
      .nrst (nrst),
      .d_in (f_data[r]),
      .v_in (f_acc),
      .d_out(feature_input2[r]),
      .v_out(in_en[r])
    );
  end

  assign w_ready       = w_ready_q;
  assign f_ready       = f_ready_q;
  assign weight_input2 = wi_q;
  assign weight_en     = wen_q;
  assign conv_ctrl     = conv_q;
  assign weight_dim    = dim_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
